// File: rtl/iq_pkg.sv
// Shared types, default sizes and lane helpers for the multi-issue
// instruction queue.
package iq_pkg;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_ENQ_W = 2;
  localparam int IQ_DEQ_W = 2;
  localparam int IQ_XLEN  = 32;

  // One queue entry as seen by decode.
  typedef struct packed {
    logic [IQ_XLEN-1:0] instr;
    logic [IQ_XLEN-1:0] pc;
  } iq_entry_t;

  // Number of set bits among the low w bits of v.
  function automatic int unsigned popcount(input logic [31:0] v, input int unsigned w);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < w && v[i]) n++;
    end
    return n;
  endfunction

  // Length of the run of ones starting at bit 0, limited to the low w bits.
  // A non-thermometer pattern therefore only yields the lanes below the
  // first zero.
  function automatic int unsigned therm_len(input logic [31:0] v, input int unsigned w);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (run && i < w) begin
        if (v[i]) n++;
        else run = 1'b0;
      end
    end
    return n;
  endfunction

  // True when the low w bits of v form a contiguous run from bit 0.
  function automatic logic is_therm(input logic [31:0] v, input int unsigned w);
    return popcount(v, w) == therm_len(v, w);
  endfunction

endpackage

// File: rtl/iq_storage_mw.sv
// Register array with ENQ_W write ports and DEQ_W read ports. Port i
// addresses base+i with natural wrap, so lanes may straddle the last slot.
module iq_storage_mw #(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 2,
  parameter int DEQ_W = 2,
  parameter int W     = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [ENQ_W-1:0]     wr_en,
  input  logic [IDX_W-1:0]     wr_base,
  input  logic [ENQ_W*W-1:0]   wr_data,
  input  logic [IDX_W-1:0]     rd_base,
  output logic [DEQ_W*W-1:0]   rd_data
);

  logic [W-1:0]     mem     [DEPTH];
  logic [IDX_W-1:0] wr_addr [ENQ_W];
  logic [IDX_W-1:0] rd_addr [DEQ_W];

  // Per-lane slot addresses; truncation to IDX_W bits is the modulo wrap.
  always_comb begin
    for (int i = 0; i < ENQ_W; i++) wr_addr[i] = wr_base + IDX_W'(i);
    for (int i = 0; i < DEQ_W; i++) rd_addr[i] = rd_base + IDX_W'(i);
  end

  // Write enabled lanes; lane addresses are distinct because ENQ_W <= DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i*W +: W];
    end
  end

  // Combinational read of the DEQ_W entries starting at the head.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEQ_W; i++) rd_data[i*W +: W] = mem[rd_addr[i]];
  end

endmodule

// File: rtl/multi_issue_instruction_queue.sv
// N-wide circular instruction queue between fetch and decode.
// Handshake: fetch presents enq_valid (thermometer from lane 0) and the
// whole group is accepted on an edge where enq_ready=1, otherwise dropped
// and fetch retries. enq_ready depends on registered count only. Decode
// sees deq_valid/deq_* combinationally and consumes deq_take head entries
// at the edge; takes beyond the valid count are clamped. flush wins over
// both sides and empties the queue.
module multi_issue_instruction_queue
  import iq_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int ENQ_W     = IQ_ENQ_W,
  parameter int DEQ_W     = IQ_DEQ_W,
  parameter int XLEN      = IQ_XLEN,
  parameter int AF_THRESH = DEPTH - 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [ENQ_W-1:0]             enq_valid,
  input  logic [ENQ_W*XLEN-1:0]        enq_instr,
  input  logic [ENQ_W*XLEN-1:0]        enq_pc,
  output logic                         enq_ready,
  output logic [DEQ_W-1:0]             deq_valid,
  output logic [DEQ_W*XLEN-1:0]        deq_instr,
  output logic [DEQ_W*XLEN-1:0]        deq_pc,
  input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = 2 * XLEN;

  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    enq_n;
  logic [CNT_W-1:0]    avail;
  logic [CNT_W-1:0]    take_n;
  logic [ENQ_W-1:0]    wr_en;
  logic [ENQ_W*EW-1:0] wr_data;
  logic [DEQ_W*EW-1:0] rd_data;

  // Handshake, accepted/consumed entry counts and status flags.
  always_comb begin
    enq_ready   = (DEPTH - int'(count)) >= ENQ_W;
    enq_n       = enq_ready ? CNT_W'(therm_len(32'(enq_valid), ENQ_W)) : '0;
    avail       = (int'(count) > DEQ_W) ? CNT_W'(DEQ_W) : count;
    take_n      = (CNT_W'(deq_take) > avail) ? avail : CNT_W'(deq_take);
    empty       = (count == '0);
    full        = (int'(count) == DEPTH);
    almost_full = (int'(count) >= AF_THRESH);
    for (int i = 0; i < DEQ_W; i++) deq_valid[i] = (int'(count) > i);
  end

  // Lane write enables and packing of {instr, pc} per lane.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      wr_en[i]            = !flush && (i < int'(enq_n));
      wr_data[i*EW +: EW] = {enq_instr[i*XLEN +: XLEN], enq_pc[i*XLEN +: XLEN]};
    end
  end

  // Unpack head entries for decode.
  always_comb begin
    deq_instr = '0;
    deq_pc    = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_instr[i*XLEN +: XLEN] = rd_data[i*EW + XLEN +: XLEN];
      deq_pc[i*XLEN +: XLEN]    = rd_data[i*EW +: XLEN];
    end
  end

  iq_storage_mw #(
    .DEPTH (DEPTH),
    .ENQ_W (ENQ_W),
    .DEQ_W (DEQ_W),
    .W     (EW),
    .IDX_W (IDX_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (tail),
    .wr_data (wr_data),
    .rd_base (head),
    .rd_data (rd_data)
  );

  // Pointer and occupancy update; flush discards both sides of the cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + IDX_W'(take_n);
      tail  <= tail + IDX_W'(enq_n);
      count <= count + enq_n - take_n;
    end
  end

endmodule

// File: tb/tb_multi_issue_instruction_queue.sv
// Self-checking bench for multi_issue_instruction_queue: directed scenarios
// plus a randomized run against a queue-based reference model.
module tb_multi_issue_instruction_queue;
  import iq_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int XLEN  = 32;
  localparam int AF    = DEPTH - 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 flush;
  logic [ENQ_W-1:0]     enq_valid;
  logic [ENQ_W*XLEN-1:0] enq_instr;
  logic [ENQ_W*XLEN-1:0] enq_pc;
  logic                 enq_ready;
  logic [DEQ_W-1:0]     deq_valid;
  logic [DEQ_W*XLEN-1:0] deq_instr;
  logic [DEQ_W*XLEN-1:0] deq_pc;
  logic [1:0]           deq_take;
  logic [4:0]           count;
  logic                 empty, full, almost_full;

  int errors = 0;
  int checks = 0;

  // Reference model: entries {instr, pc} in queue order.
  logic [63:0] mq[$];

  multi_issue_instruction_queue #(
    .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .XLEN(XLEN), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_pc(enq_pc),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .deq_take(deq_take), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // Driver: one cycle's worth of inputs.
  task automatic set_in(input logic fl, input logic [1:0] ev,
                        input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] take);
    flush     = fl;
    enq_valid = ev;
    enq_pc    = {pc1, pc0};
    enq_instr = {instr_of(pc1), instr_of(pc0)};
    deq_take  = take;
  endtask

  // Model step applied at each rising edge from the pre-edge state.
  task automatic model_apply();
    int take;
    bit ready;
    bit run;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    ready = (DEPTH - mq.size()) >= ENQ_W;
    take  = int'(deq_take);
    if (take > mq.size()) take = mq.size();
    if (take > DEQ_W) take = DEQ_W;
    repeat (take) void'(mq.pop_front());
    if (ready) begin
      run = 1'b1;
      for (int i = 0; i < ENQ_W; i++) begin
        if (run && enq_valid[i]) mq.push_back({enq_instr[i*XLEN +: XLEN], enq_pc[i*XLEN +: XLEN]});
        else run = 1'b0;
      end
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 2'b00, 0, 0, 2'd0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    set_in(1'b0, 2'b11, 32'h10, 32'h14, 2'd0);
    tick();
    set_in(1'b0, 2'b01, 32'h18, 32'h0, 2'd0);
    tick();
    if (count !== 5'd3) begin $display("FAIL reset_pre_count got=%0d exp=3", count); errors++; end
    checks++;
    // Asynchronous assertion away from any clock edge.
    set_in(1'b0, 2'b00, 0, 0, 2'd0);
    #2 rst = 1'b1;
    mq.delete();
    #1;
    if (count !== 5'd0) begin $display("FAIL reset_async_count got=%0d exp=0", count); errors++; end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      $display("FAIL reset_async_flags got e/f/af=%b%b%b exp=100", empty, full, almost_full); errors++;
    end
    checks++;
    if (enq_ready !== 1'b1 || deq_valid !== 2'b00) begin
      $display("FAIL reset_async_hs got rdy=%b dv=%b exp rdy=1 dv=00", enq_ready, deq_valid); errors++;
    end
    checks++;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (count !== 5'd0 || deq_valid !== 2'b00 || empty !== 1'b1) begin
        $display("FAIL reset_idle cyc=%0d got cnt=%0d dv=%b e=%b exp 0/00/1", k, count, deq_valid, empty); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 2'b11, 32'(8*k), 32'(8*k+4), 2'd0);
      #1;
      if (enq_ready !== 1'b1) begin $display("FAIL fill_ready cyc=%0d got=%b exp=1", k, enq_ready); errors++; end
      checks++;
      tick();
      if (count !== 5'(2*(k+1))) begin $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", k, count, 2*(k+1)); errors++; end
      checks++;
      if (almost_full !== (2*(k+1) >= 12)) begin
        $display("FAIL fill_af cyc=%0d got=%b exp=%b", k, almost_full, (2*(k+1) >= 12)); errors++;
      end
      checks++;
    end
    if (full !== 1'b1 || enq_ready !== 1'b0) begin
      $display("FAIL fill_full got full=%b rdy=%b exp full=1 rdy=0", full, enq_ready); errors++;
    end
    checks++;
    set_in(1'b0, 2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'd0);
    tick();
    if (count !== 5'd16) begin $display("FAIL fill_overflow got=%0d exp=16", count); errors++; end
    checks++;
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 2'b00, 0, 0, 2'd2);
      #1;
      if (deq_valid !== 2'b11) begin $display("FAIL drain_valid cyc=%0d got=%b exp=11", k, deq_valid); errors++; end
      checks++;
      if (deq_pc[31:0] !== 32'(8*k) || deq_pc[63:32] !== 32'(8*k+4)) begin
        $display("FAIL drain_order cyc=%0d got=%h,%h exp=%h,%h", k, deq_pc[31:0], deq_pc[63:32], 8*k, 8*k+4); errors++;
      end
      checks++;
      if (deq_instr[31:0] !== instr_of(32'(8*k))) begin
        $display("FAIL drain_instr cyc=%0d got=%h exp=%h", k, deq_instr[31:0], instr_of(32'(8*k))); errors++;
      end
      checks++;
      tick();
    end
    if (empty !== 1'b1 || count !== 5'd0) begin $display("FAIL drain_empty got e=%b cnt=%0d exp 1/0", empty, count); errors++; end
    checks++;
  endtask

  task automatic test_wrap();
    // Move head and tail to slot 15 through 15 enqueues and 15 dequeues.
    for (int k = 0; k < 7; k++) begin set_in(1'b0, 2'b11, 32'h900, 32'h904, 2'd0); tick(); end
    set_in(1'b0, 2'b01, 32'h908, 0, 2'd0); tick();
    for (int k = 0; k < 7; k++) begin set_in(1'b0, 2'b00, 0, 0, 2'd2); tick(); end
    set_in(1'b0, 2'b00, 0, 0, 2'd1); tick();
    if (count !== 5'd0) begin $display("FAIL wrap_preload got=%0d exp=0", count); errors++; end
    checks++;
    set_in(1'b0, 2'b11, 32'h100, 32'h104, 2'd0); tick();
    if (count !== 5'd2 || deq_pc[31:0] !== 32'h100 || deq_pc[63:32] !== 32'h104) begin
      $display("FAIL wrap_straddle got cnt=%0d pc=%h,%h exp 2/100,104", count, deq_pc[31:0], deq_pc[63:32]); errors++;
    end
    checks++;
    set_in(1'b0, 2'b01, 32'h108, 0, 2'd2); tick();
    if (count !== 5'd1 || deq_valid !== 2'b01 || deq_pc[31:0] !== 32'h108) begin
      $display("FAIL wrap_simul got cnt=%0d dv=%b pc=%h exp 1/01/108", count, deq_valid, deq_pc[31:0]); errors++;
    end
    checks++;
    set_in(1'b0, 2'b00, 0, 0, 2'd1); tick();
  endtask

  task automatic test_flush();
    set_in(1'b0, 2'b11, 32'h200, 32'h204, 2'd0); tick();
    set_in(1'b0, 2'b11, 32'h208, 32'h20C, 2'd0); tick();
    set_in(1'b0, 2'b01, 32'h210, 0, 2'd0); tick();
    if (count !== 5'd5) begin $display("FAIL flush_pre got=%0d exp=5", count); errors++; end
    checks++;
    set_in(1'b1, 2'b11, 32'h300, 32'h304, 2'd1); tick();
    if (count !== 5'd0 || empty !== 1'b1 || deq_valid !== 2'b00) begin
      $display("FAIL flush_clear got cnt=%0d e=%b dv=%b exp 0/1/00", count, empty, deq_valid); errors++;
    end
    checks++;
    set_in(1'b0, 2'b01, 32'h400, 0, 2'd0); tick();
    if (count !== 5'd1 || deq_pc[31:0] !== 32'h400) begin
      $display("FAIL flush_after got cnt=%0d pc=%h exp 1/400", count, deq_pc[31:0]); errors++;
    end
    checks++;
    set_in(1'b0, 2'b00, 0, 0, 2'd1); tick();
  endtask

  task automatic test_partial_illegal();
    set_in(1'b0, 2'b01, 32'h500, 0, 2'd0); tick();
    if (count !== 5'd1 || deq_valid !== 2'b01 || deq_pc[31:0] !== 32'h500) begin
      $display("FAIL partial got cnt=%0d dv=%b pc=%h exp 1/01/500", count, deq_valid, deq_pc[31:0]); errors++;
    end
    checks++;
    set_in(1'b0, 2'b00, 0, 0, 2'd2);
    #1;
    if (int'(deq_take) > popcount(32'(deq_valid), DEQ_W))
      $display("note: illegal deq_take=%0d with deq_valid=%b", deq_take, deq_valid);
    tick();
    if (count !== 5'd0 || empty !== 1'b1) begin
      $display("FAIL illegal_take_clamp got cnt=%0d e=%b exp 0/1", count, empty); errors++;
    end
    checks++;
    set_in(1'b0, 2'b10, 32'h600, 32'h604, 2'd0);
    if (!is_therm(32'(enq_valid), ENQ_W))
      $display("note: non-contiguous enq_valid=%b", enq_valid);
    tick();
    if (count !== 5'd0) begin $display("FAIL noncontig got=%0d exp=0", count); errors++; end
    checks++;
  endtask

  task automatic test_random();
    int         sz;
    int         tk;
    logic [1:0] ev;
    for (int c = 0; c < 400; c++) begin
      sz = mq.size();
      case ($urandom_range(0, 9))
        0:       ev = 2'b00;
        1, 2, 3: ev = 2'b01;
        9:       ev = 2'b10;
        default: ev = 2'b11;
      endcase
      tk = $urandom_range(0, (sz < DEQ_W) ? sz : DEQ_W);
      if ($urandom_range(0, 2) == 0) tk = 0;
      set_in(($urandom_range(0, 39) == 0), ev, $urandom, $urandom, 2'(tk));
      #1;
      if (int'(count) !== sz || count > 5'(DEPTH)) begin
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, sz); errors++;
      end
      checks++;
      if (empty !== (sz == 0) || full !== (sz == DEPTH) || almost_full !== (sz >= AF)) begin
        $display("FAIL rand_flags cyc=%0d got e/f/af=%b%b%b size=%0d", c, empty, full, almost_full, sz); errors++;
      end
      checks++;
      if (enq_ready !== ((DEPTH - sz) >= ENQ_W)) begin
        $display("FAIL rand_ready cyc=%0d got=%b size=%0d", c, enq_ready, sz); errors++;
      end
      checks++;
      for (int i = 0; i < DEQ_W; i++) begin
        if (deq_valid[i] !== (sz > i)) begin
          $display("FAIL rand_dvalid cyc=%0d lane=%0d got=%b size=%0d", c, i, deq_valid[i], sz); errors++;
        end
        checks++;
        if (sz > i) begin
          if ({deq_instr[i*XLEN +: XLEN], deq_pc[i*XLEN +: XLEN]} !== mq[i]) begin
            $display("FAIL rand_data cyc=%0d lane=%0d got=%h_%h exp=%h", c, i,
                     deq_instr[i*XLEN +: XLEN], deq_pc[i*XLEN +: XLEN], mq[i]); errors++;
          end
          checks++;
        end
      end
      tick();
    end
  endtask

  initial begin
    set_in(1'b0, 2'b00, 0, 0, 2'd0);
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_partial_illegal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
